mcycle_ctrl: RTL and testbench

- Multi-cycle control FSM that sequences the instruction-fetch, register-file decode, ALU, memory and writeback datapath one phase at a time.
- Drives the register-file control inputs (Jal, RegWrite, MemtoReg, RegDst) plus the fetch, ALU and memory enables.
- Stalls on a memory ready handshake and counts retired instructions.
- Sits between the instruction register and the datapath units, replacing single-cycle combinational control.

---
 rtl/mcycle_ctrl_if.sv | 39 +++
 rtl/mcycle_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_mcycle_ctrl.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/mcycle_ctrl_if.sv
// Control bundle between the instruction register / datapath and the multi-cycle controller.
// The master modport is the controller; the slave modport is the datapath side.
interface mcycle_ctrl_if #(
    parameter int CNT_WIDTH = 32
);
    logic [5:0]           opcode;
    logic [5:0]           funct;
    logic                 mem_ready;
    logic                 ir_en;
    logic                 pc_en;
    logic                 ALUSrc;
    logic                 Branch;
    logic                 Jr;
    logic                 MemRead;
    logic                 MemWrite;
    logic                 RegWrite;
    logic                 MemtoReg;
    logic                 RegDst;
    logic                 Jal;
    logic                 illegal;
    logic                 bus_err;
    logic                 instr_done;
    logic [CNT_WIDTH-1:0] retired;
    logic [2:0]           state;

    modport master (
        input  opcode, funct, mem_ready,
        output ir_en, pc_en, ALUSrc, Branch, Jr, MemRead, MemWrite,
               RegWrite, MemtoReg, RegDst, Jal, illegal, bus_err,
               instr_done, retired, state
    );

    modport slave (
        output opcode, funct, mem_ready,
        input  ir_en, pc_en, ALUSrc, Branch, Jr, MemRead, MemWrite,
               RegWrite, MemtoReg, RegDst, Jal, illegal, bus_err,
               instr_done, retired, state
    );
endinterface

// File: rtl/mcycle_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB controller with a retired-instruction counter.
// Optional MEM-wait abort is compiled in with `define MCYCLE_MEM_TIMEOUT_EN.
module mcycle_ctrl #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_WIDTH   = 32
) (
    input  logic          clock,
    input  logic          reset,
    mcycle_ctrl_if.master bus
);
    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4
    } state_t;

    if (MEM_TIMEOUT < 1) begin : g_bad_timeout
        $error("MEM_TIMEOUT must be at least 1");
    end

    state_t               r_state;
    state_t               w_next;
    logic [5:0]           r_op;
    logic [5:0]           r_fn;
    logic [CNT_WIDTH-1:0] r_retired;

    logic w_rtype, w_jr, w_j, w_jal, w_br, w_ialu, w_lw, w_sw, w_legal;
    logic w_ir_en, w_pc_en, w_alusrc, w_branch, w_jrsel, w_memread, w_memwrite;
    logic w_regwrite, w_memtoreg, w_regdst, w_jalsel, w_illegal, w_bus_err, w_done;
    logic w_timeout;

    // Decode works on the copy latched in FETCH, so the IR may change afterwards.
    assign w_rtype = (r_op == 6'b000000);
    assign w_jr    = w_rtype && (r_fn == 6'b001000);
    assign w_j     = (r_op == 6'b000010);
    assign w_jal   = (r_op == 6'b000011);
    assign w_br    = (r_op[5:1] == 5'b00010);
    assign w_ialu  = (r_op[5:3] == 3'b001);
    assign w_lw    = (r_op == 6'b100011);
    assign w_sw    = (r_op == 6'b101011);
    assign w_legal = w_rtype | w_j | w_jal | w_br | w_ialu | w_lw | w_sw;

`ifdef MCYCLE_MEM_TIMEOUT_EN
    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
    logic [WAIT_W-1:0] r_wait;

    // Fires in the MEM_TIMEOUT-th consecutive not-ready MEM cycle; ready wins.
    assign w_timeout = (r_state == MEM) && !bus.mem_ready &&
                       (r_wait == WAIT_W'(MEM_TIMEOUT - 1));
`else
    assign w_timeout = 1'b0;
`endif

    always_comb begin
        w_next     = FETCH;
        w_ir_en    = 1'b0;
        w_pc_en    = 1'b0;
        w_alusrc   = 1'b0;
        w_branch   = 1'b0;
        w_jrsel    = 1'b0;
        w_memread  = 1'b0;
        w_memwrite = 1'b0;
        w_regwrite = 1'b0;
        w_memtoreg = 1'b0;
        w_regdst   = 1'b0;
        w_jalsel   = 1'b0;
        w_illegal  = 1'b0;
        w_bus_err  = 1'b0;
        w_done     = 1'b0;
        case (r_state)
            FETCH: begin
                w_ir_en = 1'b1;
                w_pc_en = 1'b1;
                w_next  = DECODE;
            end
            DECODE: begin
                if (w_j) begin
                    w_pc_en = 1'b1;
                    w_done  = 1'b1;
                end else if (w_jal) begin
                    w_next = WB;
                end else if (!w_legal) begin
                    w_illegal = 1'b1;
                    w_done    = 1'b1;
                end else begin
                    w_next = EXEC;
                end
            end
            EXEC: begin
                if (w_jr) begin
                    w_jrsel = 1'b1;
                    w_pc_en = 1'b1;
                    w_done  = 1'b1;
                end else if (w_rtype) begin
                    w_next = WB;
                end else if (w_ialu) begin
                    w_alusrc = 1'b1;
                    w_next   = WB;
                end else if (w_lw || w_sw) begin
                    w_alusrc = 1'b1;
                    w_next   = MEM;
                end else begin
                    w_branch = 1'b1;
                    w_done   = 1'b1;
                end
            end
            MEM: begin
                if (w_timeout) begin
                    w_bus_err = 1'b1;
                    w_done    = 1'b1;
                end else begin
                    w_memread  = w_lw;
                    w_memwrite = w_sw;
                    if (!bus.mem_ready) begin
                        w_next = MEM;
                    end else if (w_lw) begin
                        w_next = WB;
                    end else begin
                        w_done = 1'b1;
                    end
                end
            end
            WB: begin
                w_regwrite = 1'b1;
                w_done     = 1'b1;
                w_regdst   = w_rtype;
                w_memtoreg = w_lw;
                w_jalsel   = w_jal;
            end
            default: w_next = FETCH;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= FETCH;
            r_retired <= '0;
            r_op      <= '0;
            r_fn      <= '0;
`ifdef MCYCLE_MEM_TIMEOUT_EN
            r_wait    <= '0;
`endif
        end else begin
            r_state <= w_next;
            if (r_state == FETCH) begin
                r_op <= bus.opcode;
                r_fn <= bus.funct;
            end
            if (w_done) begin
                r_retired <= r_retired + CNT_WIDTH'(1);
            end
`ifdef MCYCLE_MEM_TIMEOUT_EN
            if (w_next == MEM && r_state != MEM) begin
                r_wait <= '0;
            end else if (r_state == MEM && !bus.mem_ready) begin
                r_wait <= r_wait + WAIT_W'(1);
            end
`endif
        end
    end

    // Reset is asynchronous to the outputs: everything reads zero while it is held.
    assign bus.ir_en      = w_ir_en    & ~reset;
    assign bus.pc_en      = w_pc_en    & ~reset;
    assign bus.ALUSrc     = w_alusrc   & ~reset;
    assign bus.Branch     = w_branch   & ~reset;
    assign bus.Jr         = w_jrsel    & ~reset;
    assign bus.MemRead    = w_memread  & ~reset;
    assign bus.MemWrite   = w_memwrite & ~reset;
    assign bus.RegWrite   = w_regwrite & ~reset;
    assign bus.MemtoReg   = w_memtoreg & ~reset;
    assign bus.RegDst     = w_regdst   & ~reset;
    assign bus.Jal        = w_jalsel   & ~reset;
    assign bus.illegal    = w_illegal  & ~reset;
    assign bus.bus_err    = w_bus_err  & ~reset;
    assign bus.instr_done = w_done     & ~reset;
    assign bus.retired    = reset ? '0 : r_retired;
    assign bus.state      = reset ? 3'd0 : r_state;
endmodule

// File: tb/tb_mcycle_ctrl.sv
// Bench for mcycle_ctrl: per-instruction phase lists built from the latency/output rules,
// a vector table, hand-written reset/long-wait sequences and random instruction streams.
module tb_mcycle_ctrl;
    localparam int TO = 15;
    localparam int CW = 32;
`ifdef MCYCLE_MEM_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    typedef struct packed {
        logic [2:0] st;
        logic ir_en, pc_en, alusrc, branch, jr, memread, memwrite;
        logic regwrite, memtoreg, regdst, jal, illegal, bus_err, done;
    } cyc_t;

    typedef enum int {C_R, C_JR, C_IALU, C_LW, C_SW, C_BR, C_J, C_JAL, C_ILL} cls_t;

    typedef struct {
        string      nm;
        logic [5:0] op;
        logic [5:0] fn;
        int         nwait;
        int         lat;
    } vec_t;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    mcycle_ctrl_if #(.CNT_WIDTH(CW)) ifc ();
    mcycle_ctrl #(.MEM_TIMEOUT(TO), .CNT_WIDTH(CW)) dut (
        .clock(clock),
        .reset(reset),
        .bus  (ifc)
    );

    int n_cmp = 0;
    int n_bad = 0;
    logic [CW-1:0] exp_ret = '0;

    function automatic cls_t classify(logic [5:0] op, logic [5:0] fn);
        if (op == 6'h00) return (fn == 6'h08) ? C_JR : C_R;
        if (op[5:3] == 3'b001) return C_IALU;
        case (op)
            6'h23:        return C_LW;
            6'h2b:        return C_SW;
            6'h04, 6'h05: return C_BR;
            6'h02:        return C_J;
            6'h03:        return C_JAL;
            default:      return C_ILL;
        endcase
    endfunction

    function automatic cyc_t sample();
        return {ifc.state, ifc.ir_en, ifc.pc_en, ifc.ALUSrc, ifc.Branch, ifc.Jr,
                ifc.MemRead, ifc.MemWrite, ifc.RegWrite, ifc.MemtoReg, ifc.RegDst,
                ifc.Jal, ifc.illegal, ifc.bus_err, ifc.instr_done};
    endfunction

    task automatic check_cyc(input string nm, input int i, input cyc_t want);
        cyc_t got;
        got = sample();
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s cyc %0d outputs: got %h want %h", nm, i, got, want);
        end
        n_cmp++;
        if (ifc.retired !== exp_ret) begin
            n_bad++;
            $display("FAIL %s cyc %0d retired: got %0d want %0d", nm, i, ifc.retired, exp_ret);
        end
    endtask

    // One instruction from its FETCH cycle to its final cycle. nwait = not-ready MEM cycles
    // before mem_ready rises; lat returns the cycle count at which instr_done was seen.
    task automatic run_instr(input string nm, input logic [5:0] op, input logic [5:0] fn,
                             input int nwait, output int lat);
        cyc_t exp_q[$];
        int   rdy_q[$];
        cyc_t c;
        cls_t k;
        bit   tmo;
        int   mcount;
        k = classify(op, fn);
        c = '0; c.st = 3'd0; c.ir_en = 1; c.pc_en = 1;
        exp_q.push_back(c); rdy_q.push_back(-1);
        c = '0; c.st = 3'd1;
        if (k == C_J) begin c.pc_en = 1; c.done = 1; end
        if (k == C_ILL) begin c.illegal = 1; c.done = 1; end
        exp_q.push_back(c); rdy_q.push_back(-1);
        if (k != C_J && k != C_ILL && k != C_JAL) begin
            c = '0; c.st = 3'd2;
            if (k == C_JR) begin c.jr = 1; c.pc_en = 1; c.done = 1; end
            if (k == C_BR) begin c.branch = 1; c.done = 1; end
            if (k == C_IALU || k == C_LW || k == C_SW) c.alusrc = 1;
            exp_q.push_back(c); rdy_q.push_back(-1);
        end
        tmo = TO_EN && (nwait >= TO);
        mcount = tmo ? TO : nwait + 1;
        if (k == C_LW || k == C_SW) begin
            for (int m = 0; m < mcount; m++) begin
                c = '0; c.st = 3'd3;
                if (tmo && m == mcount - 1) begin
                    c.bus_err = 1; c.done = 1;
                end else begin
                    c.memread  = (k == C_LW);
                    c.memwrite = (k == C_SW);
                    if (!tmo && m == mcount - 1 && k == C_SW) c.done = 1;
                end
                exp_q.push_back(c); rdy_q.push_back(m == nwait ? 1 : 0);
            end
        end
        if (k == C_R || k == C_IALU || k == C_JAL || (k == C_LW && !tmo)) begin
            c = '0; c.st = 3'd4; c.regwrite = 1; c.done = 1;
            c.regdst = (k == C_R); c.memtoreg = (k == C_LW); c.jal = (k == C_JAL);
            exp_q.push_back(c); rdy_q.push_back(-1);
        end
        lat = -1;
        for (int i = 0; i < exp_q.size(); i++) begin
            @(negedge clock);
            ifc.opcode    = (i == 0) ? op : 6'($urandom);
            ifc.funct     = (i == 0) ? fn : 6'($urandom);
            ifc.mem_ready = (rdy_q[i] < 0) ? 1'($urandom) : 1'(rdy_q[i]);
            #1;
            check_cyc(nm, i, exp_q[i]);
            if (lat < 0 && ifc.instr_done === 1'b1) lat = i + 1;
            if (exp_q[i].done) exp_ret = exp_ret + 1;
        end
    endtask

    vec_t tbl[14];
    logic [5:0] ops[12];
    cyc_t w;
    int lat;

    initial begin
        tbl = '{
            '{"add",     6'h00, 6'h20, 0, 4},
            '{"lw_w3",   6'h23, 6'h11, 3, 8},
            '{"jal",     6'h03, 6'h00, 0, 3},
            '{"jr",      6'h00, 6'h08, 0, 3},
            '{"illegal", 6'h3f, 6'h00, 0, 2},
            '{"addi",    6'h08, 6'h2a, 0, 4},
            '{"lui",     6'h0f, 6'h00, 0, 4},
            '{"sw_w0",   6'h2b, 6'h00, 0, 4},
            '{"sw_w2",   6'h2b, 6'h08, 2, 6},
            '{"beq",     6'h04, 6'h00, 0, 3},
            '{"bne",     6'h05, 6'h08, 0, 3},
            '{"j",       6'h02, 6'h08, 0, 2},
            '{"lw_w0",   6'h23, 6'h00, 0, 5},
            '{"andi",    6'h0c, 6'h3f, 0, 4}
        };
        ops = '{6'h00, 6'h00, 6'h08, 6'h0d, 6'h23, 6'h2b, 6'h04, 6'h05,
                6'h02, 6'h03, 6'h3f, 6'h1c};

        reset = 1'b1;
        ifc.opcode = 6'h2b; ifc.funct = 6'h08; ifc.mem_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clock); #1;
            check_cyc("reset", i, '0);
        end
        @(posedge clock); #1;
        reset = 1'b0;

        foreach (tbl[i]) begin
            run_instr(tbl[i].nm, tbl[i].op, tbl[i].fn, tbl[i].nwait, lat);
            n_cmp++;
            if (lat != tbl[i].lat) begin
                n_bad++;
                $display("FAIL %s latency: got %0d want %0d", tbl[i].nm, lat, tbl[i].lat);
            end
        end

        // Ready in the last cycle before the abort point still completes normally.
        run_instr("lw_w14", 6'h23, 6'h00, TO - 1, lat);
        n_cmp++;
        if (lat != TO + 4) begin
            n_bad++;
            $display("FAIL lw_w14 latency: got %0d want %0d", lat, TO + 4);
        end

        // Never-ready load: aborts in MEM cycle TO, or simply keeps waiting.
        run_instr("lw_stall", 6'h23, 6'h00, 120, lat);
        n_cmp++;
        if (lat != (TO_EN ? 3 + TO : 125)) begin
            n_bad++;
            $display("FAIL lw_stall latency: got %0d want %0d", lat, TO_EN ? 3 + TO : 125);
        end

        // Store abandoned by reset during its second MEM wait cycle.
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            ifc.opcode    = (i == 0) ? 6'h2b : 6'($urandom);
            ifc.funct     = 6'($urandom);
            ifc.mem_ready = (i == 5);
            if (i == 4) begin reset = 1'b1; exp_ret = '0; end
            #1;
            w = '0;
            case (i)
                0: begin w.ir_en = 1; w.pc_en = 1; end
                1: w.st = 3'd1;
                2: begin w.st = 3'd2; w.alusrc = 1; end
                3: begin w.st = 3'd3; w.memwrite = 1; end
                default: w = '0;
            endcase
            check_cyc("sw_reset", i, w);
        end
        @(posedge clock); #1;
        reset = 1'b0;
        run_instr("add_after_reset", 6'h00, 6'h22, 0, lat);

        for (int r = 0; r < 300; r++) begin
            logic [5:0] op, fn;
            int nw;
            op = ops[$urandom_range(0, 11)];
            if ($urandom_range(0, 9) == 0) op = 6'($urandom);
            fn = ($urandom_range(0, 3) == 0) ? 6'h08 : 6'($urandom);
            nw = ($urandom_range(0, 15) == 0) ? $urandom_range(12, 20) : $urandom_range(0, 4);
            run_instr("random", op, fn, nw, lat);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
